// File: rtl/pipelined_addsub_if.sv
// Operand/result stream bundle for pipelined_addsub.
//   master: producer/consumer side (drives operands and out_ready)
//   slave : adder side (drives in_ready and the registered results)
//   in_valid/in_ready/mode/a/b/cin : operand stream
//   out_valid/out_ready/sum/cout/ovf/zero : result stream
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, mode, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, mode, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor with valid/ready streaming.
// Each of STAGES register stages adds WIDTH/STAGES bits and hands its carry on.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of pipelined_addsub_if
//          operands in (in_valid/in_ready, mode, a, b, cin)
//          results out (out_valid/out_ready, sum, cout, ovf, zero)
// in_ready is the only combinational output and depends only on
// out_valid and out_ready (global stall).
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic               clk,
  input  logic               rst,
  pipelined_addsub_if.slave  bus
);

  localparam int unsigned SW = WIDTH / STAGES;

  // Stage registers: partial sum, operands (high bits still pending),
  // running carry, operand MSBs for overflow, and valid.
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic              am_q  [STAGES];
  logic              am_d  [STAGES];
  logic              bm_q  [STAGES];
  logic              bm_d  [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              zero_q;
  logic              zero_d;

  // Per-stage inputs: stage 0 takes the prepared operands, others the
  // previous stage register.
  logic [WIDTH-1:0]  sum_in [STAGES];
  logic [WIDTH-1:0]  a_in   [STAGES];
  logic [WIDTH-1:0]  b_in   [STAGES];
  logic              am_in  [STAGES];
  logic              bm_in  [STAGES];
  logic              c_in   [STAGES];
  logic              v_in   [STAGES];
  logic [SW:0]       part   [STAGES];

  logic              stall;

  // Global stall: a held result freezes every stage.
  assign stall        = v_q[STAGES-1] & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // Stage input selection; subtract is a + ~b + ~cin.
  always_comb begin
    sum_in[0] = '0;
    a_in[0]   = bus.a;
    b_in[0]   = bus.mode ? ~bus.b : bus.b;
    c_in[0]   = bus.mode ^ bus.cin;
    am_in[0]  = bus.a[WIDTH-1];
    bm_in[0]  = bus.mode ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
    v_in[0]   = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      sum_in[k] = sum_q[k-1];
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      c_in[k]   = c_q[k-1];
      am_in[k]  = am_q[k-1];
      bm_in[k]  = bm_q[k-1];
      v_in[k]   = v_q[k-1];
    end
  end

  // Slice adders and next-state for every stage, plus final flags.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      part[k] = (SW+1)'(a_in[k][k*SW +: SW]) + (SW+1)'(b_in[k][k*SW +: SW])
              + (SW+1)'(c_in[k]);
      sum_d[k]              = sum_in[k];
      sum_d[k][k*SW +: SW]  = part[k][SW-1:0];
      a_d[k]                = a_in[k];
      b_d[k]                = b_in[k];
      am_d[k]               = am_in[k];
      bm_d[k]               = bm_in[k];
      c_d[k]                = part[k][SW];
      v_d[k]                = v_in[k];
    end
    ovf_d  = (am_in[STAGES-1] == bm_in[STAGES-1]) &&
             (sum_d[STAGES-1][WIDTH-1] != am_in[STAGES-1]);
    zero_d = ~|sum_d[STAGES-1];
  end

  // Pipeline registers; all hold while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        am_q[k]  <= 1'b0;
        bm_q[k]  <= 1'b0;
      end
      c_q    <= '0;
      v_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        am_q[k]  <= am_d[k];
        bm_q[k]  <= bm_d[k];
      end
      c_q    <= c_d;
      v_q    <= v_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = sum_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed and random checks of pipelined_addsub at 16/4, 8/1 and 32/8.
module tb_pipelined_addsub;

  localparam int S16 = 4;
  localparam int S8  = 1;
  localparam int S32 = 8;
  localparam int N   = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(16)) bus16 ();
  pipelined_addsub_if #(.WIDTH(8))  bus8  ();
  pipelined_addsub_if #(.WIDTH(32)) bus32 ();

  pipelined_addsub #(.WIDTH(16), .STAGES(S16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  pipelined_addsub #(.WIDTH(8),  .STAGES(S8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  pipelined_addsub #(.WIDTH(32), .STAGES(S32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  int n_chk;
  int n_fail;
  int cyc_n;
  bit lat_chk;
  bit stalled;
  logic [35:0] held;
  logic [34:0] exp_q [$];
  int          lat_q [$];

  logic [31:0] ra [N];
  logic [31:0] rb [N];
  logic        rm [N];
  logic        rc [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, {zero, ovf, cout, sum}.
  function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic m, input logic c);
    longint full, half, ua, ub, uc, r, sa, sb, sr;
    logic [31:0] s;
    logic co, ov;
    full = longint'(1) << w;
    half = full >> 1;
    ua = longint'(a) & (full - 1);
    ub = longint'(b) & (full - 1);
    uc = longint'(c);
    if (!m) begin
      r  = ua + ub + uc;
      co = (r >= full);
    end else begin
      r  = ua - ub - uc;
      co = (ua >= ub + uc);
    end
    s  = 32'(r & (full - 1));
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    sr = m ? sa - sb - uc : sa + sb + uc;
    ov = (sr >= half) || (sr < -half);
    return {(s == 32'h0), ov, co, s};
  endfunction

  function automatic logic [34:0] pk(input logic z, input logic o, input logic c, input logic [15:0] s);
    return {z, o, c, 16'h0, s};
  endfunction

  function automatic logic [34:0] obs16();
    return {bus16.zero, bus16.ovf, bus16.cout, 16'h0, bus16.sum};
  endfunction

  // One cycle on the 16-bit DUT: drive, check at negedge, advance.
  task automatic cyc(input logic iv, input logic [15:0] a, input logic [15:0] b, input logic m,
                     input logic c, input logic ordy, input logic [34:0] e, output logic acc);
    logic [34:0] ev;
    int lt;
    bus16.in_valid  = iv;
    bus16.a         = a;
    bus16.b         = b;
    bus16.mode      = m;
    bus16.cin       = c;
    bus16.out_ready = ordy;
    #4;
    if (stalled) chk("stall_hold", 64'({bus16.out_valid, obs16()}), 64'(held));
    chk("in_ready", 64'(bus16.in_ready), 64'(!(bus16.out_valid && !ordy)));
    if (bus16.out_valid && ordy) begin
      chk("out_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        lt = lat_q.pop_front();
        chk("result", 64'(obs16()), 64'(ev));
        if (lat_chk) chk("latency", 64'(cyc_n - lt), 64'(S16));
      end
    end
    acc = iv && bus16.in_ready;
    if (acc) begin
      exp_q.push_back(e);
      lat_q.push_back(cyc_n);
    end
    stalled = bus16.out_valid && !ordy;
    held    = {bus16.out_valid, obs16()};
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic drain(input int max);
    logic acc;
    for (int i = 0; i < max && exp_q.size() > 0; i++)
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 35'h0, acc);
    chk("drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    logic acc;
    int idx;
    n_chk = 0; n_fail = 0; cyc_n = 0; lat_chk = 1'b1; stalled = 1'b0; held = '0;
    rst = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.mode = 1'b0; bus16.cin = 1'b0;
    bus16.out_ready = 1'b0;
    bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.mode  = 1'b0; bus8.cin  = 1'b0;
    bus8.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.mode = 1'b0; bus32.cin = 1'b0;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      ra[i] = $urandom();
      rb[i] = $urandom();
      rm[i] = 1'($urandom_range(1, 0));
      rc[i] = 1'($urandom_range(1, 0));
    end

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus16.out_valid), 64'(0));
    chk("rst_result", 64'(obs16()), 64'(0));
    chk("rst_in_ready", 64'(bus16.in_ready), 64'(1));
    chk("rst_out_valid8", 64'(bus8.out_valid), 64'(0));
    chk("rst_out_valid32", 64'(bus32.out_valid), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Carry across a slice boundary, with exact latency
    cyc(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, pk(0, 0, 0, 16'h0100), acc);
    drain(20);

    // Signed overflow and wrap to zero
    cyc(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, pk(0, 1, 0, 16'h8000), acc);
    cyc(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, pk(1, 0, 1, 16'h0000), acc);
    drain(20);

    // Subtraction: borrow, equal operands, overflow, borrow-in
    cyc(1'b1, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1, pk(0, 0, 0, 16'hFFFF), acc);
    cyc(1'b1, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b1, pk(1, 0, 1, 16'h0000), acc);
    cyc(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, pk(0, 1, 1, 16'h7FFF), acc);
    cyc(1'b1, 16'h0005, 16'h0002, 1'b1, 1'b1, 1'b1, pk(0, 0, 1, 16'h0002), acc);
    drain(20);

    // Back-to-back random stream, full throughput
    for (int i = 0; i < N; i++)
      cyc(1'b1, ra[i][15:0], rb[i][15:0], rm[i], rc[i], 1'b1,
          model(16, ra[i], rb[i], rm[i], rc[i]), acc);
    drain(20);

    // Random back-pressure: operands held until accepted
    lat_chk = 1'b0;
    idx = 0;
    for (int t = 0; t < 200 && idx < N; t++) begin
      cyc(1'b1, rb[idx][15:0], ra[idx][15:0], ~rm[idx], rc[idx], 1'($urandom_range(1, 0)),
          model(16, rb[idx], ra[idx], ~rm[idx], rc[idx]), acc);
      if (acc) idx++;
    end
    chk("accept_bound", 64'(idx), 64'(N));
    drain(100);

    // Asynchronous reset with three operations in flight and output stalled
    cyc(1'b1, 16'h0010, 16'h0001, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 16'h0011), acc);
    cyc(1'b1, 16'h0020, 16'h0002, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 16'h0022), acc);
    cyc(1'b1, 16'h0030, 16'h0003, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 16'h0033), acc);
    cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 35'h0, acc);
    cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 35'h0, acc);
    chk("pre_reset_valid", 64'(bus16.out_valid), 64'(1));
    chk("pre_reset_in_ready", 64'(bus16.in_ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("async_out_valid", 64'(bus16.out_valid), 64'(0));
    chk("async_result", 64'(obs16()), 64'(0));
    chk("async_in_ready", 64'(bus16.in_ready), 64'(1));
    exp_q.delete();
    lat_q.delete();
    stalled = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    cyc(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1, pk(0, 0, 0, 16'h0007), acc);
    drain(20);

    // WIDTH=8, STAGES=1: latency 1, back-to-back
    for (int t = 0; t < N + S8; t++) begin
      bus8.in_valid = (t < N);
      if (t < N) begin
        bus8.a = ra[t][7:0]; bus8.b = rb[t][7:0]; bus8.mode = rm[t]; bus8.cin = rc[t];
      end
      #4;
      if (t >= S8) begin
        chk("w8_valid", 64'(bus8.out_valid), 64'(1));
        chk("w8_result", 64'({bus8.zero, bus8.ovf, bus8.cout, 24'h0, bus8.sum}),
            64'(model(8, ra[t-S8], rb[t-S8], rm[t-S8], rc[t-S8])));
      end else begin
        chk("w8_early", 64'(bus8.out_valid), 64'(0));
      end
      @(posedge clk);
      #1;
    end
    #4;
    chk("w8_idle", 64'(bus8.out_valid), 64'(0));
    @(posedge clk);
    #1;

    // WIDTH=32, STAGES=8: latency 8, back-to-back
    for (int t = 0; t < N + S32; t++) begin
      bus32.in_valid = (t < N);
      if (t < N) begin
        bus32.a = ra[t]; bus32.b = rb[t]; bus32.mode = rm[t]; bus32.cin = rc[t];
      end
      #4;
      if (t >= S32) begin
        chk("w32_valid", 64'(bus32.out_valid), 64'(1));
        chk("w32_result", 64'({bus32.zero, bus32.ovf, bus32.cout, bus32.sum}),
            64'(model(32, ra[t-S32], rb[t-S32], rm[t-S32], rc[t-S32])));
      end else begin
        chk("w32_early", 64'(bus32.out_valid), 64'(0));
      end
      @(posedge clk);
      #1;
    end
    #4;
    chk("w32_idle", 64'(bus32.out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
